// File: rtl/bsg_fsb_mitm_relay.sv
// Man-in-the-middle relay between an FSB ring port and one master node, with per-direction
// pass/drop/hold modes and an upstream packet injector. Counters built when BSG_FSB_MITM_STATS_EN is defined.

module bsg_fsb_mitm_relay_fifo #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o
);
  logic [width_p-1:0] mem_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (enq_i) wptr_q <= ~wptr_q;
      if (deq_i) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, enq_i} - {1'b0, deq_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wptr_q] <= data_i;
  end

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign data_o  = mem_q[rptr_q];
endmodule

module bsg_fsb_mitm_relay #(
  parameter  int ring_width_p = 32,
  parameter  int inject_els_p = 8,
  parameter  int cnt_width_p  = 16,
  localparam int addr_w_lp    = (inject_els_p > 1) ? $clog2(inject_els_p) : 1,
  localparam int len_w_lp     = $clog2(inject_els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [1:0]              mode_up_i,
  input  logic [1:0]              mode_down_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  input  logic                    from_master_v_i,
  input  logic [ring_width_p-1:0] from_master_data_i,
  output logic                    from_master_ready_o,
  output logic                    to_master_v_o,
  output logic [ring_width_p-1:0] to_master_data_o,
  input  logic                    to_master_yumi_i,
  input  logic                    cfg_w_v_i,
  input  logic [addr_w_lp-1:0]    cfg_addr_i,
  input  logic [ring_width_p-1:0] cfg_data_i,
  input  logic                    start_i,
  input  logic [len_w_lp-1:0]     inject_len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [cnt_width_p-1:0]  up_xfer_cnt_o,
  output logic [cnt_width_p-1:0]  up_drop_cnt_o,
  output logic [cnt_width_p-1:0]  down_xfer_cnt_o,
  output logic [cnt_width_p-1:0]  down_drop_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} inj_state_e;
  localparam logic [1:0] M_PASS = 2'd0, M_DROP = 2'd1, M_INJECT = 2'd2, M_HOLD = 2'd3;

  // Keeps every ready low while reset is held, even in DROP/INJECT modes.
  logic alive_q;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) alive_q <= 1'b0;
    else            alive_q <= 1'b1;
  end

  logic                    up_full, up_empty, up_enq, up_deq, up_pass, up_discard;
  logic                    inj_push;
  logic [ring_width_p-1:0] up_enq_data, inj_data;

  assign up_pass             = (mode_up_i == M_PASS);
  assign up_discard          = (mode_up_i == M_DROP) || (mode_up_i == M_INJECT);
  assign from_master_ready_o = alive_q & ((up_pass & ~up_full) | up_discard);
  assign v_o                 = ~up_empty & (mode_up_i != M_HOLD);
  assign up_deq              = v_o & yumi_i;
  assign up_enq              = (from_master_v_i & from_master_ready_o & up_pass) | inj_push;
  assign up_enq_data         = inj_push ? inj_data : from_master_data_i;

  bsg_fsb_mitm_relay_fifo #(.width_p(ring_width_p)) up_fifo (
    .clk_i, .reset_n_i, .enq_i(up_enq), .data_i(up_enq_data), .deq_i(up_deq),
    .full_o(up_full), .empty_o(up_empty), .data_o(data_o)
  );

  logic down_full, down_empty, down_enq, down_deq, down_pass, down_drop;

  assign down_pass     = (mode_down_i == M_PASS);
  assign down_drop     = (mode_down_i == M_DROP);
  assign ready_o       = alive_q & ((down_pass & ~down_full) | down_drop);
  assign to_master_v_o = ~down_empty & ~mode_down_i[1];
  assign down_deq      = to_master_v_o & to_master_yumi_i;
  assign down_enq      = v_i & ready_o & down_pass;

  bsg_fsb_mitm_relay_fifo #(.width_p(ring_width_p)) down_fifo (
    .clk_i, .reset_n_i, .enq_i(down_enq), .data_i(data_i), .deq_i(down_deq),
    .full_o(down_full), .empty_o(down_empty), .data_o(to_master_data_o)
  );

  inj_state_e              state_q, state_d;
  logic [len_w_lp-1:0]     ptr_q, ptr_d, len_q, len_d, len_clamped;
  logic [ring_width_p-1:0] inj_mem_q [inject_els_p];
  logic                    inj_mode;

  assign inj_mode    = (mode_up_i == M_INJECT);
  assign len_clamped = (inject_len_i > len_w_lp'(inject_els_p)) ? len_w_lp'(inject_els_p)
                                                                : inject_len_i;
  assign inj_data    = inj_mem_q[ptr_q[addr_w_lp-1:0]];
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);

  // The sequence buffer is frozen while a run is reading it.
  always_ff @(posedge clk_i) begin
    if (cfg_w_v_i && (state_q != RUN)) inj_mem_q[cfg_addr_i] <= cfg_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    inj_push = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i && inj_mode) begin
          ptr_d   = '0;
          len_d   = len_clamped;
          state_d = (len_clamped == '0) ? DONE : RUN;
        end else if (state_q == DONE && !inj_mode) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!inj_mode) begin
          state_d = IDLE;
        end else if (!up_full) begin
          inj_push = 1'b1;
          ptr_d    = ptr_q + len_w_lp'(1);
          if (ptr_q == len_q - len_w_lp'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BSG_FSB_MITM_STATS_EN
  logic [cnt_width_p-1:0] up_xfer_q, up_drop_q, down_xfer_q, down_drop_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      up_xfer_q   <= '0;
      up_drop_q   <= '0;
      down_xfer_q <= '0;
      down_drop_q <= '0;
    end else begin
      if (up_deq && !(&up_xfer_q)) up_xfer_q <= up_xfer_q + cnt_width_p'(1);
      if (from_master_v_i && from_master_ready_o && up_discard && !(&up_drop_q))
        up_drop_q <= up_drop_q + cnt_width_p'(1);
      if (down_deq && !(&down_xfer_q)) down_xfer_q <= down_xfer_q + cnt_width_p'(1);
      if (v_i && ready_o && down_drop && !(&down_drop_q))
        down_drop_q <= down_drop_q + cnt_width_p'(1);
    end
  end

  assign up_xfer_cnt_o   = up_xfer_q;
  assign up_drop_cnt_o   = up_drop_q;
  assign down_xfer_cnt_o = down_xfer_q;
  assign down_drop_cnt_o = down_drop_q;
`else
  assign up_xfer_cnt_o   = '0;
  assign up_drop_cnt_o   = '0;
  assign down_xfer_cnt_o = '0;
  assign down_drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bsg_fsb_mitm_relay.sv
// Bench for bsg_fsb_mitm_relay: mode decode table, scoreboarded traffic in both directions,
// hold/drop/inject sequences and asynchronous reset mid-run.

module tb_bsg_fsb_mitm_relay;
  localparam int W = 16, ELS = 8, CW = 16;
`ifdef BSG_FSB_MITM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [1:0]    mode_up_i = 2'd1, mode_down_i = 2'd1;
  logic          v_i = 1'b0, yumi_i = 1'b0, from_master_v_i = 1'b0, to_master_yumi_i = 1'b0;
  logic [W-1:0]  data_i = '0, from_master_data_i = '0, cfg_data_i = '0;
  logic          cfg_w_v_i = 1'b0, start_i = 1'b0;
  logic [2:0]    cfg_addr_i = '0;
  logic [3:0]    inject_len_i = '0;
  logic          ready_o, v_o, from_master_ready_o, to_master_v_o, busy_o, done_o;
  logic [W-1:0]  data_o, to_master_data_o;
  logic [CW-1:0] up_xfer_cnt_o, up_drop_cnt_o, down_xfer_cnt_o, down_drop_cnt_o;

  always #5 clk = ~clk;

  bsg_fsb_mitm_relay #(.ring_width_p(W), .inject_els_p(ELS), .cnt_width_p(CW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .mode_up_i(mode_up_i), .mode_down_i(mode_down_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .from_master_v_i(from_master_v_i), .from_master_data_i(from_master_data_i),
    .from_master_ready_o(from_master_ready_o), .to_master_v_o(to_master_v_o),
    .to_master_data_o(to_master_data_o), .to_master_yumi_i(to_master_yumi_i),
    .cfg_w_v_i(cfg_w_v_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .start_i(start_i), .inject_len_i(inject_len_i), .busy_o(busy_o), .done_o(done_o),
    .up_xfer_cnt_o(up_xfer_cnt_o), .up_drop_cnt_o(up_drop_cnt_o),
    .down_xfer_cnt_o(down_xfer_cnt_o), .down_drop_cnt_o(down_drop_cnt_o)
  );

  int           nchk = 0, nfail = 0;
  int           dn_out = 0, up_out = 0;
  logic [W-1:0] dq[$], uq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: words accepted in PASS are expected out in order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (v_i && ready_o && mode_down_i == 2'd0) dq.push_back(data_i);
      if (from_master_v_i && from_master_ready_o && mode_up_i == 2'd0)
        uq.push_back(from_master_data_i);
      if (to_master_v_o && to_master_yumi_i) begin
        dn_out++;
        if (dq.size() == 0) chk("down_unexpected_word", 1, 0);
        else chk("down_data", to_master_data_o, dq.pop_front());
      end
      if (v_o && yumi_i) begin
        up_out++;
        if (uq.size() == 0) chk("up_unexpected_word", 1, 0);
        else chk("up_data", data_o, uq.pop_front());
      end
    end
  end

  typedef struct {
    logic [1:0] mu, md;
    logic       e_rdy, e_fm_rdy;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t         vecs[5];
    logic [W-1:0] inj_a[4];
    logic [W-1:0] inj_b[6];
    int           base_up, base_dn, n;

    vecs[0] = '{2'd0, 2'd0, 1'b1, 1'b1};
    vecs[1] = '{2'd1, 2'd1, 1'b1, 1'b1};
    vecs[2] = '{2'd2, 2'd2, 1'b0, 1'b1};
    vecs[3] = '{2'd3, 2'd3, 1'b0, 1'b0};
    vecs[4] = '{2'd0, 2'd3, 1'b0, 1'b1};
    inj_a = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    inj_b = '{16'h1E01, 16'h1E02, 16'h1E03, 16'h1E04, 16'h1E05, 16'h1E06};

    // Reset state, with DROP modes so ready gating during reset is visible.
    tick(); tick(); smp();
    chk("rst_ready_o", ready_o, 0);
    chk("rst_fm_ready", from_master_ready_o, 0);
    chk("rst_v_o", v_o, 0);
    chk("rst_tm_v", to_master_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_up_xfer", up_xfer_cnt_o, 0);
    chk("rst_dn_drop", down_drop_cnt_o, 0);
    tick();
    reset_n = 1'b1;
    tick(); tick();

    for (int i = 0; i < 5; i++) begin
      mode_up_i = vecs[i].mu;
      mode_down_i = vecs[i].md;
      smp();
      chk($sformatf("vec%0d_ready_o", i), ready_o, vecs[i].e_rdy);
      chk($sformatf("vec%0d_fm_ready", i), from_master_ready_o, vecs[i].e_fm_rdy);
      chk($sformatf("vec%0d_v_o", i), v_o, 0);
      chk($sformatf("vec%0d_tm_v", i), to_master_v_o, 0);
      tick();
    end

    // Both PASS, 20 words each way, sinks always ready.
    mode_up_i = 2'd0; mode_down_i = 2'd0; yumi_i = 1'b1; to_master_yumi_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      v_i = 1'b1; data_i = W'($urandom);
      from_master_v_i = 1'b1; from_master_data_i = W'($urandom);
      smp();
      chk($sformatf("pass_tm_v%0d", k), to_master_v_o, k != 0);
      chk($sformatf("pass_v_o%0d", k), v_o, k != 0);
      chk($sformatf("pass_ready%0d", k), ready_o & from_master_ready_o, 1);
      tick();
    end
    v_i = 1'b0; from_master_v_i = 1'b0;
    smp();
    chk("pass_tail_v", {v_o, to_master_v_o}, 2'b11);
    tick(); smp();
    chk("pass_drained_v", {v_o, to_master_v_o}, 2'b00);
    chk("pass_dn_count", dn_out, 20);
    chk("pass_up_count", up_out, 20);
    chk("pass_up_xfer_cnt", up_xfer_cnt_o, STATS ? 20 : 0);
    chk("pass_dn_xfer_cnt", down_xfer_cnt_o, STATS ? 20 : 0);
    tick();

    // Down HOLD with two words buffered, third word offered.
    to_master_yumi_i = 1'b0; base_dn = dn_out;
    for (int k = 0; k < 2; k++) begin
      v_i = 1'b1; data_i = 16'h5100 + 16'(k);
      tick();
    end
    mode_down_i = 2'd2; data_i = 16'h5102;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("hold_ready%0d", k), ready_o, 0);
      chk($sformatf("hold_tm_v%0d", k), to_master_v_o, 0);
      to_master_yumi_i = 1'b1;
      tick();
    end
    v_i = 1'b0; mode_down_i = 2'd0;
    repeat (4) tick();
    smp();
    chk("hold_release_count", dn_out - base_dn, 2);
    chk("hold_queue_empty", dq.size(), 0);
    chk("hold_dn_xfer_cnt", down_xfer_cnt_o, STATS ? 22 : 0);
    tick();

    // Up DROP, 5 master words; down DROP, 3 FSB words.
    mode_up_i = 2'd1; mode_down_i = 2'd1;
    for (int k = 0; k < 5; k++) begin
      from_master_v_i = 1'b1; from_master_data_i = W'($urandom);
      v_i = (k < 3); data_i = W'($urandom);
      smp();
      chk($sformatf("drop_fm_ready%0d", k), from_master_ready_o, 1);
      chk($sformatf("drop_v_o%0d", k), v_o, 0);
      chk($sformatf("drop_tm_v%0d", k), to_master_v_o, 0);
      tick();
    end
    from_master_v_i = 1'b0; v_i = 1'b0;
    smp();
    chk("drop_up_cnt", up_drop_cnt_o, STATS ? 5 : 0);
    chk("drop_dn_cnt", down_drop_cnt_o, STATS ? 3 : 0);
    tick();

    // Inject A..D, FSB consuming every other cycle.
    yumi_i = 1'b0; base_up = up_out;
    for (int i = 0; i < 4; i++) begin
      cfg_w_v_i = 1'b1; cfg_addr_i = 3'(i); cfg_data_i = inj_a[i];
      tick();
    end
    cfg_w_v_i = 1'b0;
    for (int i = 0; i < 4; i++) uq.push_back(inj_a[i]);
    mode_up_i = 2'd2; start_i = 1'b1; inject_len_i = 4'd4;
    tick();
    start_i = 1'b0;
    smp();
    chk("inj4_busy_start", busy_o, 1);
    for (n = 0; n < 60; n++) begin
      smp();
      if (done_o && uq.size() == 0) break;
      tick();
      yumi_i = ~yumi_i;
    end
    chk("inj4_timeout", n < 60, 1);
    chk("inj4_done", done_o, 1);
    chk("inj4_busy_end", busy_o, 0);
    chk("inj4_words", up_out - base_up, 4);
    chk("inj4_up_xfer_cnt", up_xfer_cnt_o, STATS ? 24 : 0);
    tick();

    // Inject len=6, mode back to PASS after two pushes.
    yumi_i = 1'b1; base_up = up_out;
    for (int i = 0; i < 6; i++) begin
      cfg_w_v_i = 1'b1; cfg_addr_i = 3'(i); cfg_data_i = inj_b[i];
      tick();
    end
    cfg_w_v_i = 1'b0;
    uq.push_back(inj_b[0]); uq.push_back(inj_b[1]);
    start_i = 1'b1; inject_len_i = 4'd6;
    tick();
    start_i = 1'b0;
    smp();
    chk("inj6_busy", busy_o, 1);
    chk("inj6_done_cleared", done_o, 0);
    tick(); tick();
    mode_up_i = 2'd0;
    tick(); smp();
    chk("inj6_abort_busy", busy_o, 0);
    chk("inj6_abort_done", done_o, 0);
    repeat (3) tick();
    smp();
    chk("inj6_words", up_out - base_up, 2);
    chk("inj6_queue_empty", uq.size(), 0);
    tick();

    // Fill both FIFOs with injector stalled in RUN, then reset asynchronously.
    yumi_i = 1'b0; to_master_yumi_i = 1'b0;
    mode_up_i = 2'd2; mode_down_i = 2'd0;
    start_i = 1'b1; inject_len_i = 4'd15;
    v_i = 1'b1; data_i = 16'h7001;
    tick();
    start_i = 1'b0; data_i = 16'h7002;
    tick();
    v_i = 1'b0;
    repeat (3) tick();
    smp();
    chk("full_busy", busy_o, 1);
    chk("full_valids", {v_o, to_master_v_o}, 2'b11);
    chk("full_ready_o", ready_o, 0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valids", {v_o, to_master_v_o}, 2'b00);
    chk("arst_busy", busy_o, 0);
    chk("arst_readys", {ready_o, from_master_ready_o}, 2'b00);
    dq.delete(); uq.delete();
    tick(); tick();
    reset_n = 1'b1;
    mode_up_i = 2'd0; yumi_i = 1'b1; to_master_yumi_i = 1'b1;
    tick(); tick();
    base_up = up_out; base_dn = dn_out;
    for (int k = 0; k < 3; k++) begin
      v_i = 1'b1; data_i = W'($urandom);
      from_master_v_i = 1'b1; from_master_data_i = W'($urandom);
      tick();
    end
    v_i = 1'b0; from_master_v_i = 1'b0;
    repeat (3) tick();
    smp();
    chk("post_rst_dn_words", dn_out - base_dn, 3);
    chk("post_rst_up_words", up_out - base_up, 3);
    chk("post_rst_up_xfer_cnt", up_xfer_cnt_o, STATS ? 3 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
